// File: rtl/instruction_fetch_unit_if.sv
// Fetch-side bundle: hazard/redirect controls, instruction memory port and the IF/ID register outputs.
// master = fetch unit, slave = surrounding pipeline and memory.
interface instruction_fetch_unit_if;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_read;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_busywait;
    logic [31:0] if_id_instruction;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;

    modport master (
        input  stall, redirect_valid, redirect_pc, imem_rdata, imem_busywait,
        output imem_read, imem_addr, if_id_instruction, if_id_pc, if_id_pc_plus4, if_id_valid
    );

    modport slave (
        output stall, redirect_valid, redirect_pc, imem_rdata, imem_busywait,
        input  imem_read, imem_addr, if_id_instruction, if_id_pc, if_id_pc_plus4, if_id_valid
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch with IF/ID register: one word per cycle on zero-wait memory, 1-cycle memory-to-IF/ID latency.
// Backpressure: stall holds IF/ID (a completing word parks in a one-entry skid buffer); busywait holds the request.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
    input  logic                        clk,
    input  logic                        rst_n,
    instruction_fetch_unit_if.master    bus
);

    typedef enum logic [1:0] {FETCH, DRAIN, HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] target_q, target_d;
    logic [31:0] buf_insn_q, buf_insn_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] insn_q, insn_d;
    logic [31:0] ifpc_q, ifpc_d;
    logic [31:0] ifpc4_q, ifpc4_d;
    logic        valid_q, valid_d;

    logic        complete;
    logic [31:0] redirect_target;
    logic [31:0] pc_plus4;

    // Request is suppressed while reset is held so nothing is issued before rst_n rises.
    assign bus.imem_read         = rst_n && (state_q != HOLD);
    assign bus.imem_addr         = pc_q;
    assign bus.if_id_instruction = insn_q;
    assign bus.if_id_pc          = ifpc_q;
    assign bus.if_id_pc_plus4    = ifpc4_q;
    assign bus.if_id_valid       = valid_q;

    assign complete        = bus.imem_read && !bus.imem_busywait;
    assign redirect_target = bus.redirect_pc & ~32'd3;
    assign pc_plus4        = pc_q + 32'd4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        target_d   = target_q;
        buf_insn_d = buf_insn_q;
        buf_pc_d   = buf_pc_q;
        insn_d     = insn_q;
        ifpc_d     = ifpc_q;
        ifpc4_d    = ifpc4_q;
        valid_d    = valid_q;

        case (state_q)
            FETCH: begin
                if (bus.redirect_valid) begin
                    insn_d  = NOP_INSN;
                    valid_d = 1'b0;
                    if (complete) begin
                        pc_d = redirect_target;
                    end else begin
                        target_d = redirect_target;
                        state_d  = DRAIN;
                    end
                end else if (complete) begin
                    if (bus.stall) begin
                        buf_insn_d = bus.imem_rdata;
                        buf_pc_d   = pc_q;
                        pc_d       = pc_plus4;
                        state_d    = HOLD;
                    end else begin
                        insn_d  = bus.imem_rdata;
                        ifpc_d  = pc_q;
                        ifpc4_d = pc_plus4;
                        valid_d = 1'b1;
                        pc_d    = pc_plus4;
                    end
                end else if (!bus.stall) begin
                    insn_d  = NOP_INSN;
                    valid_d = 1'b0;
                end
            end
            DRAIN: begin
                // The stale request must finish before the target can be issued; its word is dropped.
                insn_d  = NOP_INSN;
                valid_d = 1'b0;
                if (bus.redirect_valid) begin
                    target_d = redirect_target;
                end
                if (complete) begin
                    pc_d    = bus.redirect_valid ? redirect_target : target_q;
                    state_d = FETCH;
                end
            end
            HOLD: begin
                if (bus.redirect_valid) begin
                    buf_insn_d = 32'd0;
                    buf_pc_d   = 32'd0;
                    pc_d       = redirect_target;
                    insn_d     = NOP_INSN;
                    valid_d    = 1'b0;
                    state_d    = FETCH;
                end else if (!bus.stall) begin
                    insn_d  = buf_insn_q;
                    ifpc_d  = buf_pc_q;
                    ifpc4_d = buf_pc_q + 32'd4;
                    valid_d = 1'b1;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            target_q   <= 32'd0;
            buf_insn_q <= 32'd0;
            buf_pc_q   <= 32'd0;
            insn_q     <= NOP_INSN;
            ifpc_q     <= 32'd0;
            ifpc4_q    <= 32'd0;
            valid_q    <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            target_q   <= target_d;
            buf_insn_q <= buf_insn_d;
            buf_pc_q   <= buf_pc_d;
            insn_q     <= insn_d;
            ifpc_q     <= ifpc_d;
            ifpc4_q    <= ifpc4_d;
            valid_q    <= valid_d;
        end
    end

endmodule
